midi_msg_parser: RTL and testbench

- Sequencing controller downstream of the MIDI UART byte receiver.
- Consumes received bytes plus the framing-error strobe and tracks MIDI running status.
- Assembles complete channel-voice messages and presents each as a single-cycle event to the synth/entry logic.
- Filters by channel, normalises note-on with velocity 0 to note-off, and passes system real-time bytes through without disturbing message assembly.

---
 rtl/midi_pkg.sv | 35 +++
 rtl/midi_status_len.sv | 30 +++
 rtl/midi_msg_parser.sv | 169 ++++++++++++++++
 tb/tb_midi_msg_parser.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants: status byte class boundaries, channel-voice message
// types and the receive parser state encoding.
package midi_pkg;

  localparam logic [7:0] STATUS_CHAN_MIN = 8'h80;
  localparam logic [7:0] SYSEX_START     = 8'hF0;
  localparam logic [7:0] SYSEX_EOX       = 8'hF7;
  localparam logic [7:0] RT_MIN          = 8'hF8;

  typedef enum logic [2:0] {
    MT_NOTE_OFF   = 3'd0,
    MT_NOTE_ON    = 3'd1,
    MT_POLY_AT    = 3'd2,
    MT_CC         = 3'd3,
    MT_PROGRAM    = 3'd4,
    MT_CHAN_AT    = 3'd5,
    MT_PITCH_BEND = 3'd6
  } msg_type_t;

  typedef enum logic [2:0] {
    CLS_DATA   = 3'd0,
    CLS_CHAN   = 3'd1,
    CLS_SYSEX  = 3'd2,
    CLS_SYSCOM = 3'd3,
    CLS_RT     = 3'd4
  } byte_class_t;

  typedef enum logic [1:0] {
    ST_NO_STATUS = 2'd0,
    ST_WAIT_D1   = 2'd1,
    ST_WAIT_D2   = 2'd2,
    ST_SYSEX     = 2'd3
  } state_t;

endpackage

// File: rtl/midi_status_len.sv
// Combinational MIDI byte classifier: returns the byte class and, for channel
// status bytes, the number of data bytes the message carries.
module midi_status_len
  import midi_pkg::*;
(
  input  logic [7:0] status_byte,
  output logic [2:0] byte_class,
  output logic [1:0] exp_len
);

  always_comb begin
    byte_class = CLS_DATA;
    exp_len    = 2'd0;
    // Real-time first: it overlaps the 0xF_ range of the system bytes.
    if (status_byte >= RT_MIN) begin
      byte_class = CLS_RT;
    end else if (status_byte == SYSEX_START) begin
      byte_class = CLS_SYSEX;
    end else if (status_byte > SYSEX_START && status_byte <= SYSEX_EOX) begin
      byte_class = CLS_SYSCOM;
    end else if (status_byte >= STATUS_CHAN_MIN) begin
      byte_class = CLS_CHAN;
      if (status_byte[6:4] == MT_PROGRAM || status_byte[6:4] == MT_CHAN_AT)
        exp_len = 2'd1;
      else
        exp_len = 2'd2;
    end
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI receive-side message assembler: running status, channel filter,
// note-on/velocity-0 normalisation, real-time pass-through, error counting.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_framing_error,
  input  logic [3:0]               cfg_channel,
  input  logic                     cfg_omni,
  output logic                     msg_valid,
  output logic [2:0]               msg_type,
  output logic [3:0]               msg_channel,
  output logic [6:0]               msg_data1,
  output logic [6:0]               msg_data2,
  output logic                     rt_valid,
  output logic [7:0]               rt_byte,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     sysex_active
);

  logic [2:0] byte_class;
  logic [1:0] exp_len;

  midi_status_len u_status_len (
    .status_byte (rx_data),
    .byte_class  (byte_class),
    .exp_len     (exp_len)
  );

  state_t                   state_reg, state_next;
  logic [6:0]               status_reg, status_next;
  logic                     len2_reg, len2_next;
  logic [6:0]               data1_reg, data1_next;
  logic                     msg_valid_reg, msg_valid_next;
  logic [2:0]               msg_type_reg, msg_type_next;
  logic [3:0]               msg_channel_reg, msg_channel_next;
  logic [6:0]               msg_data1_reg, msg_data1_next;
  logic [6:0]               msg_data2_reg, msg_data2_next;
  logic                     rt_valid_reg, rt_valid_next;
  logic [7:0]               rt_byte_reg, rt_byte_next;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg, err_count_next;

  logic       emit;
  logic [2:0] emit_type;
  logic [6:0] emit_d1;
  logic [6:0] emit_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_NO_STATUS;
      status_reg      <= '0;
      len2_reg        <= 1'b0;
      data1_reg       <= '0;
      msg_valid_reg   <= 1'b0;
      msg_type_reg    <= '0;
      msg_channel_reg <= '0;
      msg_data1_reg   <= '0;
      msg_data2_reg   <= '0;
      rt_valid_reg    <= 1'b0;
      rt_byte_reg     <= '0;
      err_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      status_reg      <= status_next;
      len2_reg        <= len2_next;
      data1_reg       <= data1_next;
      msg_valid_reg   <= msg_valid_next;
      msg_type_reg    <= msg_type_next;
      msg_channel_reg <= msg_channel_next;
      msg_data1_reg   <= msg_data1_next;
      msg_data2_reg   <= msg_data2_next;
      rt_valid_reg    <= rt_valid_next;
      rt_byte_reg     <= rt_byte_next;
      err_count_reg   <= err_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    status_next      = status_reg;
    len2_next        = len2_reg;
    data1_next       = data1_reg;
    msg_valid_next   = 1'b0;
    msg_type_next    = msg_type_reg;
    msg_channel_next = msg_channel_reg;
    msg_data1_next   = msg_data1_reg;
    msg_data2_next   = msg_data2_reg;
    rt_valid_next    = 1'b0;
    rt_byte_next     = rt_byte_reg;
    err_count_next   = err_count_reg;
    emit             = 1'b0;
    emit_d1          = '0;
    emit_d2          = '0;
    emit_type        = status_reg[6:4];

    if (rx_framing_error) begin
      // A bad stop bit poisons whatever was being assembled, including the byte.
      state_next  = ST_NO_STATUS;
      status_next = '0;
      data1_next  = '0;
      if (err_count_reg != {ERR_CNT_WIDTH{1'b1}})
        err_count_next = err_count_reg + ERR_CNT_WIDTH'(1);
    end else if (rx_valid) begin
      case (byte_class)
        CLS_RT: begin
          rt_valid_next = 1'b1;
          rt_byte_next  = rx_data;
        end
        CLS_CHAN: begin
          status_next = rx_data[6:0];
          len2_next   = (exp_len == 2'd2);
          state_next  = ST_WAIT_D1;
        end
        CLS_SYSEX: begin
          status_next = '0;
          state_next  = ST_SYSEX;
        end
        CLS_SYSCOM: begin
          status_next = '0;
          state_next  = ST_NO_STATUS;
        end
        default: begin
          if (state_reg == ST_WAIT_D1) begin
            if (len2_reg) begin
              data1_next = rx_data[6:0];
              state_next = ST_WAIT_D2;
            end else begin
              emit    = 1'b1;
              emit_d1 = rx_data[6:0];
            end
          end else if (state_reg == ST_WAIT_D2) begin
            emit       = 1'b1;
            emit_d1    = data1_reg;
            emit_d2    = rx_data[6:0];
            state_next = ST_WAIT_D1;
          end
        end
      endcase
    end

    if (emit_type == MT_NOTE_ON && emit_d2 == 7'd0)
      emit_type = MT_NOTE_OFF;

    // Filtered messages still advance running status above; only the pulse is dropped.
    if (emit && (cfg_omni || status_reg[3:0] == cfg_channel)) begin
      msg_valid_next   = 1'b1;
      msg_type_next    = emit_type;
      msg_channel_next = status_reg[3:0];
      msg_data1_next   = emit_d1;
      msg_data2_next   = emit_d2;
    end
  end

  assign msg_valid    = msg_valid_reg;
  assign msg_type     = msg_type_reg;
  assign msg_channel  = msg_channel_reg;
  assign msg_data1    = msg_data1_reg;
  assign msg_data2    = msg_data2_reg;
  assign rt_valid     = rt_valid_reg;
  assign rt_byte      = rt_byte_reg;
  assign err_count    = err_count_reg;
  assign sysex_active = (state_reg == ST_SYSEX);

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: byte-level reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_framing_error = 1'b0;
  logic [3:0] cfg_channel = '0;
  logic       cfg_omni = 1'b1;
  logic       msg_valid;
  logic [2:0] msg_type;
  logic [3:0] msg_channel;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic [7:0] err_count;
  logic       sysex_active;

  midi_msg_parser #(.ERR_CNT_WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_framing_error (rx_framing_error),
    .cfg_channel      (cfg_channel),
    .cfg_omni         (cfg_omni),
    .msg_valid        (msg_valid),
    .msg_type         (msg_type),
    .msg_channel      (msg_channel),
    .msg_data1        (msg_data1),
    .msg_data2        (msg_data2),
    .rt_valid         (rt_valid),
    .rt_byte          (rt_byte),
    .err_count        (err_count),
    .sysex_active     (sysex_active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk = 1'b0;
  int sx_cycles = 0;
  logic [20:0] got_q[$];   // {type, ch, d1, d2}
  logic [7:0]  rt_q[$];

  // Reference model state
  int         m_rs;        // running status byte, -1 when none
  int         m_nd;
  logic [6:0] m_dbuf[2];
  bit         m_sx;
  int         m_err;
  bit         m_mv, m_rv;
  logic [2:0] m_type;
  logic [3:0] m_ch;
  logic [6:0] m_d1, m_d2;
  logic [7:0] m_rb;
  logic [39:0] exp_vec = '0;

  function automatic logic [39:0] dut_vec();
    return {msg_valid, msg_type, msg_channel, msg_data1, msg_data2,
            rt_valid, rt_byte, err_count, sysex_active};
  endfunction

  function automatic logic [39:0] model_vec();
    logic [7:0] e8;
    e8 = 8'(m_err);
    return {m_mv, m_type, m_ch, m_d1, m_d2, m_rv, m_rb, e8, m_sx};
  endfunction

  task automatic model_reset();
    m_rs = -1; m_nd = 0; m_sx = 0; m_err = 0; m_mv = 0; m_rv = 0;
    m_type = 0; m_ch = 0; m_d1 = 0; m_d2 = 0; m_rb = 0;
    m_dbuf[0] = 0; m_dbuf[1] = 0;
  endtask

  task automatic model(input bit v, input logic [7:0] b, input bit fe, input bit r);
    int need;
    int ty;
    logic [6:0] d2;
    m_mv = 0; m_rv = 0;
    if (r) begin
      model_reset();
    end else if (fe) begin
      m_rs = -1; m_nd = 0; m_sx = 0;
      if (m_err < 255) m_err++;
    end else if (v) begin
      if (b >= 8'hF8) begin
        m_rv = 1; m_rb = b;
      end else if (b >= 8'h80 && b < 8'hF0) begin
        m_rs = int'(b); m_nd = 0; m_sx = 0;
      end else if (b == 8'hF0) begin
        m_rs = -1; m_nd = 0; m_sx = 1;
      end else if (b > 8'hF0) begin
        m_rs = -1; m_nd = 0; m_sx = 0;
      end else if (m_rs >= 0) begin
        need = (((m_rs >> 4) == 'hC) || ((m_rs >> 4) == 'hD)) ? 1 : 2;
        m_dbuf[m_nd] = b[6:0];
        m_nd++;
        if (m_nd == need) begin
          m_nd = 0;
          ty = (m_rs >> 4) & 7;
          d2 = (need == 2) ? m_dbuf[1] : 7'd0;
          if (ty == 1 && d2 == 0) ty = 0;
          if (cfg_omni || (m_rs & 15) == int'(cfg_channel)) begin
            m_mv = 1; m_type = 3'(ty); m_ch = 4'(m_rs & 15);
            m_d1 = m_dbuf[0]; m_d2 = d2;
          end
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit fe, input bit r);
    @(negedge clk);
    rx_valid = v; rx_data = b; rx_framing_error = fe; rst = r;
    model(v, b, fe, r);
    @(posedge clk);
    #1;
    exp_vec = model_vec();
    rx_valid = 0; rx_framing_error = 0; rst = 0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else
      $display("[TB] ok %s: %h", name, act);
  endtask

  task automatic expect_msg(input string name, input logic [20:0] req);
    logic [20:0] got;
    got = '1;
    if (got_q.size() > 0) got = got_q.pop_front();
    check(name, 40'(got), 40'(req));
  endtask

  task automatic expect_none(input string name);
    check(name, 40'(got_q.size()), 40'd0);
    got_q.delete();
  endtask

  always @(negedge clk) begin
    if (chk) begin
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++;
        $display("FAIL cycle @%0t: outputs %h required %h", $time, dut_vec(), exp_vec);
      end
      if (msg_valid) got_q.push_back({msg_type, msg_channel, msg_data1, msg_data2});
      if (rt_valid) rt_q.push_back(rt_byte);
      if (sysex_active) sx_cycles++;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", dut_vec(), 40'd0);
    model_reset();
    exp_vec = '0;
    chk = 1'b1;

    // Note-on, omni
    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    expect_msg("note_on", {3'd1, 4'd0, 7'h3C, 7'h64});
    expect_none("note_on_count");

    // Running status with velocity-0 conversion
    send(8'h91); send(8'h40); send(8'h7F); send(8'h40); send(8'h00); idle(2);
    expect_msg("rs_first", {3'd1, 4'd1, 7'h40, 7'h7F});
    expect_msg("rs_vel0_off", {3'd0, 4'd1, 7'h40, 7'h00});
    expect_none("rs_count");

    // Real-time interleaved inside a CC
    rt_q.delete();
    send(8'hB2); send(8'h07); send(8'hF8); send(8'h50); idle(2);
    check("rt_count", 40'(rt_q.size()), 40'd1);
    if (rt_q.size() > 0) check("rt_byte", 40'(rt_q[0]), 40'hF8);
    expect_msg("cc_rt", {3'd3, 4'd2, 7'h07, 7'h50});
    expect_none("cc_count");

    // Program change with channel filter
    cfg_channel = 4'd3; cfg_omni = 1'b0;
    send(8'hC5); send(8'h10); send(8'hC3); send(8'h20); idle(2);
    expect_msg("prog_filter", {3'd4, 4'd3, 7'h20, 7'h00});
    expect_none("prog_count");
    cfg_omni = 1'b1; cfg_channel = 4'd0;

    // SysEx drops running status
    send(8'h90); send(8'h3C); send(8'h64); idle(1);
    expect_msg("pre_sysex", {3'd1, 4'd0, 7'h3C, 7'h64});
    sx_cycles = 0;
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h3C); send(8'h64); idle(2);
    check("sysex_cycles", 40'(sx_cycles), 40'd3);
    expect_none("post_sysex_none");

    // Channel aftertouch running status and pitch bend
    send(8'hD4); send(8'h11); send(8'h22); send(8'hE0); send(8'h01); send(8'h02); idle(2);
    expect_msg("chan_at_1", {3'd5, 4'd4, 7'h11, 7'h00});
    expect_msg("chan_at_2", {3'd5, 4'd4, 7'h22, 7'h00});
    expect_msg("pitch_bend", {3'd6, 4'd0, 7'h01, 7'h02});
    expect_none("at_pb_count");

    // Framing error mid-message, then error colliding with a valid byte
    send(8'h90); send(8'h3C); step(1'b0, 8'h00, 1'b1, 1'b0); send(8'h3C); send(8'h64); idle(1);
    expect_none("fe_no_pulse");
    check("err_count_1", 40'(err_count), 40'd1);
    step(1'b1, 8'h90, 1'b1, 1'b0); send(8'h3C); send(8'h64); idle(1);
    expect_none("fe_collide_no_pulse");
    check("err_count_2", 40'(err_count), 40'd2);
    for (int i = 0; i < 254; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    check("err_count_sat", 40'(err_count), 40'hFF);

    // Reset mid-message loses the partial message
    send(8'h90); send(8'h3C); step(1'b0, 8'h00, 1'b0, 1'b1); send(8'h64); idle(2);
    expect_none("rst_no_pulse");
    check("rst_err_clear", 40'(err_count), 40'd0);

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
